// File: rtl/cache_data_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_data_port_ctrl_if
// Bundles the signals between the cache FSM, the data-port controller and the
// 64x128-bit data RAM.
//   req_*   : 64-bit word request (valid/ready), write data and byte strobes
//   resp_*  : response (valid/ready) carrying the selected read half
//   scan_*  : full-RAM row-scan control and row stream (valid/ready)
//   ram_*   : RAM macro pins; CEN/WEN/BWEN are active-low, Q is registered
// Modports: slave = the controller, master = the environment (FSM + RAM).
// -----------------------------------------------------------------------------
interface cache_data_port_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [6:0]   req_addr;
    logic [63:0]  req_wdata;
    logic [7:0]   req_wstrb;
    logic         resp_valid;
    logic         resp_ready;
    logic [63:0]  resp_rdata;
    logic         scan_start;
    logic         scan_busy;
    logic         scan_valid;
    logic         scan_ready;
    logic [5:0]   scan_idx;
    logic [127:0] scan_data;
    logic         ram_CEN;
    logic         ram_WEN;
    logic [5:0]   ram_A;
    logic [127:0] ram_BWEN;
    logic [127:0] ram_D;
    logic [127:0] ram_Q;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  resp_ready, scan_start, scan_ready, ram_Q,
        output req_ready, resp_valid, resp_rdata,
        output scan_busy, scan_valid, scan_idx, scan_data,
        output ram_CEN, ram_WEN, ram_A, ram_BWEN, ram_D
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output resp_ready, scan_start, scan_ready, ram_Q,
        input  req_ready, resp_valid, resp_rdata,
        input  scan_busy, scan_valid, scan_idx, scan_data,
        input  ram_CEN, ram_WEN, ram_A, ram_BWEN, ram_D
    );
endinterface

// File: rtl/cache_data_port_ctrl.sv
// -----------------------------------------------------------------------------
// cache_data_port_ctrl
// Initiator-side controller for the cache data RAM (64 rows x 128 bits).
// Converts 64-bit word requests into RAM strobes with a per-bit write mask,
// returns the selected read half through a valid/ready response, and runs a
// row-scan mode that streams every row out for writeback/flush.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous reset, active-high
//   port_if : request/response/scan/RAM bundle (slave side)
// RAM strobes are driven combinationally in the accepting cycle so the
// registered RAM output lines up with the response one cycle later.
// -----------------------------------------------------------------------------
module cache_data_port_ctrl #(
    parameter int ROWS = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cache_data_port_ctrl_if.slave  port_if
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RESP     = 2'd1;
    localparam logic [1:0] ST_SCAN_RD  = 2'd2;
    localparam logic [1:0] ST_SCAN_OUT = 2'd3;
    localparam logic [5:0] LAST_ROW    = 6'(ROWS - 1);

    logic [1:0]   state_q, state_d;
    logic [5:0]   row_q, row_d;
    logic         half_q, half_d;
    logic         wr_q, wr_d;

    logic         req_ready_s;
    logic         scan_go_s;
    logic         ram_cen_s;
    logic         ram_wen_s;
    logic [5:0]   ram_a_s;
    logic [127:0] ram_bwen_s;
    logic [127:0] ram_d_s;

    // Active-low bit write mask: byte b of the selected half is written when
    // wstrb[b] is set; the other half is always masked off.
    function automatic logic [127:0] build_bwen(input logic half, input logic [7:0] wstrb);
        logic [127:0] mask;
        logic [6:0]   base;
        mask = {128{1'b1}};
        for (int b = 0; b < 8; b++) begin
            base = {half, 3'(b), 3'b000};
            mask[base +: 8] = {8{~wstrb[b]}};
        end
        return mask;
    endfunction

    // Handshake qualifiers; reset and a scan start both block request acceptance.
    always_comb begin
        req_ready_s = (state_q == ST_IDLE) && !rst_i && !port_if.scan_start;
        scan_go_s   = (state_q == ST_IDLE) && !rst_i && port_if.scan_start;
    end

    // Next-state logic and RAM strobe generation.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        half_d     = half_q;
        wr_d       = wr_q;
        ram_cen_s  = 1'b1;
        ram_wen_s  = 1'b1;
        ram_a_s    = 6'd0;
        ram_bwen_s = {128{1'b1}};
        ram_d_s    = 128'd0;
        case (state_q)
            ST_IDLE: begin
                if (scan_go_s) begin
                    row_d   = 6'd0;
                    state_d = ST_SCAN_RD;
                end else if (req_ready_s && port_if.req_valid) begin
                    half_d  = port_if.req_addr[0];
                    wr_d    = port_if.req_write;
                    state_d = ST_RESP;
                    if (!port_if.req_write) begin
                        ram_cen_s = 1'b0;
                        ram_a_s   = port_if.req_addr[6:1];
                    end else if (port_if.req_wstrb != 8'd0) begin
                        ram_cen_s  = 1'b0;
                        ram_wen_s  = 1'b0;
                        ram_a_s    = port_if.req_addr[6:1];
                        ram_d_s    = {port_if.req_wdata, port_if.req_wdata};
                        ram_bwen_s = build_bwen(port_if.req_addr[0], port_if.req_wstrb);
                    end else begin
                        // Empty strobe: skip the RAM but still answer.
                        ram_cen_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                // No RAM access here, so ram_Q holds under backpressure.
                if (port_if.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_SCAN_RD: begin
                ram_cen_s = 1'b0;
                ram_a_s   = row_q;
                state_d   = ST_SCAN_OUT;
            end
            ST_SCAN_OUT: begin
                if (port_if.scan_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_IDLE;
                    end else begin
                        row_d   = row_q + 6'd1;
                        state_d = ST_SCAN_RD;
                    end
                end else begin
                    state_d = ST_SCAN_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, scan row counter and response bookkeeping registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            row_q   <= 6'd0;
            half_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            half_q  <= half_d;
            wr_q    <= wr_d;
        end
    end

    // Output drive; response data comes straight from the registered RAM output.
    always_comb begin
        port_if.req_ready  = req_ready_s;
        port_if.resp_valid = (state_q == ST_RESP);
        if ((state_q == ST_RESP) && !wr_q) begin
            port_if.resp_rdata = half_q ? port_if.ram_Q[127:64] : port_if.ram_Q[63:0];
        end else begin
            port_if.resp_rdata = 64'd0;
        end
        port_if.scan_busy  = (state_q == ST_SCAN_RD) || (state_q == ST_SCAN_OUT);
        port_if.scan_valid = (state_q == ST_SCAN_OUT);
        port_if.scan_idx   = row_q;
        if (state_q == ST_SCAN_OUT) begin
            port_if.scan_data = port_if.ram_Q;
        end else begin
            port_if.scan_data = 128'd0;
        end
        port_if.ram_CEN  = ram_cen_s;
        port_if.ram_WEN  = ram_wen_s;
        port_if.ram_A    = ram_a_s;
        port_if.ram_BWEN = ram_bwen_s;
        port_if.ram_D    = ram_d_s;
    end

endmodule

// File: tb/tb_cache_data_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_data_port_ctrl
// Directed bench for cache_data_port_ctrl with a behavioural 64x128 RAM that
// honours active-low CEN/WEN/BWEN and returns read data one cycle later.
// -----------------------------------------------------------------------------
module tb_cache_data_port_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_data_port_ctrl_if bus();

    cache_data_port_ctrl #(.ROWS(64)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .port_if (bus)
    );

    // Behavioural RAM: masked write, registered read held until the next read.
    logic [127:0] mem [64];
    logic [127:0] q_r;
    assign bus.ram_Q = q_r;

    always @(posedge clk) begin
        if (!bus.ram_CEN) begin
            if (!bus.ram_WEN) begin
                mem[bus.ram_A] <= (mem[bus.ram_A] & bus.ram_BWEN) | (bus.ram_D & ~bus.ram_BWEN);
            end else begin
                q_r <= mem[bus.ram_A];
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_req(input logic [6:0] addr, input logic [63:0] data, input logic [7:0] strb);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wstrb = strb;
        #1;
        chk("wr_ready", 128'(bus.req_ready), 128'(1'b1));
    endtask

    task automatic wr_finish();
        step();
        bus.req_valid = 1'b0;
        #1;
        chk("wr_resp_valid", 128'(bus.resp_valid), 128'(1'b1));
        chk("wr_resp_rdata", 128'(bus.resp_rdata), 128'd0);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("wr_resp_done", 128'(bus.resp_valid), 128'(1'b0));
    endtask

    task automatic rd(input logic [6:0] addr, input logic [63:0] exp, input int stall);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        bus.req_wstrb = 8'h00;
        #1;
        chk("rd_ready", 128'(bus.req_ready), 128'(1'b1));
        chk("rd_cen", 128'(bus.ram_CEN), 128'(1'b0));
        chk("rd_wen", 128'(bus.ram_WEN), 128'(1'b1));
        chk("rd_addr", 128'(bus.ram_A), 128'(addr[6:1]));
        step();
        chk("rd_resp_valid", 128'(bus.resp_valid), 128'(1'b1));
        chk("rd_resp_rdata", 128'(bus.resp_rdata), 128'(exp));
        // Keep a new request pending during the stall; it must not be taken.
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", 128'(bus.resp_valid), 128'(1'b1));
            chk("stall_rdata", 128'(bus.resp_rdata), 128'(exp));
            chk("stall_req_ready", 128'(bus.req_ready), 128'(1'b0));
            chk("stall_cen", 128'(bus.ram_CEN), 128'(1'b1));
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("rd_resp_done", 128'(bus.resp_valid), 128'(1'b0));
    endtask

    initial begin
        int  e;
        bit  found;
        rst            = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 7'h00;
        bus.req_wdata  = 64'd0;
        bus.req_wstrb  = 8'h00;
        bus.resp_ready = 1'b0;
        bus.scan_start = 1'b0;
        bus.scan_ready = 1'b0;

        // Reset state, with a request pending that must be ignored.
        repeat (3) step();
        chk("rst_req_ready", 128'(bus.req_ready), 128'(1'b0));
        chk("rst_resp_valid", 128'(bus.resp_valid), 128'(1'b0));
        chk("rst_scan_valid", 128'(bus.scan_valid), 128'(1'b0));
        chk("rst_scan_busy", 128'(bus.scan_busy), 128'(1'b0));
        chk("rst_resp_rdata", 128'(bus.resp_rdata), 128'd0);
        chk("rst_scan_idx", 128'(bus.scan_idx), 128'd0);
        chk("rst_cen", 128'(bus.ram_CEN), 128'(1'b1));
        chk("rst_wen", 128'(bus.ram_WEN), 128'(1'b1));
        chk("rst_bwen", bus.ram_BWEN, {128{1'b1}});
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(bus.req_ready), 128'(1'b1));
        step();

        // Full write of row 2 low half.
        wr_req(7'h04, 64'hCAFEBABEDEADBEEF, 8'hFF);
        chk("wr04_bwen", bus.ram_BWEN, {64'hFFFFFFFFFFFFFFFF, 64'h0});
        wr_finish();

        // Full write of row 2 high half.
        wr_req(7'h05, 64'h1122334455667788, 8'hFF);
        chk("wr05_cen", 128'(bus.ram_CEN), 128'(1'b0));
        chk("wr05_wen", 128'(bus.ram_WEN), 128'(1'b0));
        chk("wr05_addr", 128'(bus.ram_A), 128'd2);
        chk("wr05_bwen", bus.ram_BWEN, {64'h0, 64'hFFFFFFFFFFFFFFFF});
        chk("wr05_d", bus.ram_D, {64'h1122334455667788, 64'h1122334455667788});
        wr_finish();
        rd(7'h05, 64'h1122334455667788, 0);

        // Partial write: low four bytes of the high half.
        wr_req(7'h05, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        chk("wr0f_bwen", bus.ram_BWEN, {32'hFFFFFFFF, 32'h0, 64'hFFFFFFFFFFFFFFFF});
        wr_finish();
        rd(7'h05, 64'h11223344AAAAAAAA, 0);
        rd(7'h04, 64'hCAFEBABEDEADBEEF, 0);

        // Response backpressure for five cycles.
        rd(7'h05, 64'h11223344AAAAAAAA, 5);

        // Empty strobe: no RAM access, still one zero response.
        wr_req(7'h04, 64'h0123456789ABCDEF, 8'h00);
        chk("wr00_cen", 128'(bus.ram_CEN), 128'(1'b1));
        wr_finish();
        rd(7'h04, 64'hCAFEBABEDEADBEEF, 0);

        // Sparse strobe 0xA5 on row 5 low half: bytes 0,2,5,7 written.
        wr_req(7'h0A, 64'h5555555555555555, 8'hA5);
        chk("wra5_bwen", bus.ram_BWEN, {64'hFFFFFFFFFFFFFFFF, 64'h00FF00FFFF00FF00});
        chk("wra5_addr", 128'(bus.ram_A), 128'd5);
        wr_finish();

        // Reset while a response is pending drops it.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 7'h04;
        step();
        bus.req_valid = 1'b0;
        chk("mid_resp_valid", 128'(bus.resp_valid), 128'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst_resp_drop", 128'(bus.resp_valid), 128'(1'b0));
        chk("rst_resp_cen", 128'(bus.ram_CEN), 128'(1'b1));
        step();
        rst = 1'b0;
        #1;
        chk("rst_resp_ready", 128'(bus.req_ready), 128'(1'b1));

        // Fill every row with {r, r}.
        for (int r = 0; r < 64; r++) begin
            wr_req({6'(r), 1'b0}, 64'(r), 8'hFF);
            wr_finish();
            wr_req({6'(r), 1'b1}, 64'(r), 8'hFF);
            wr_finish();
        end

        // Scan start wins over a simultaneous request.
        bus.scan_start = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 7'h00;
        #1;
        chk("start_req_ready", 128'(bus.req_ready), 128'(1'b0));
        chk("start_cen", 128'(bus.ram_CEN), 128'(1'b1));
        step();
        bus.scan_start = 1'b0;
        bus.req_valid  = 1'b0;
        chk("start_no_resp", 128'(bus.resp_valid), 128'(1'b0));
        chk("start_busy", 128'(bus.scan_busy), 128'(1'b1));

        // Stream all rows with random backpressure.
        e = 0;
        for (int cyc = 0; cyc < 2000 && e < 64; cyc++) begin
            bus.scan_ready = 1'($urandom_range(0, 1));
            if (bus.scan_valid) begin
                chk("scan_idx", 128'(bus.scan_idx), 128'(e));
                chk("scan_data", bus.scan_data, {64'(e), 64'(e)});
                if (bus.scan_ready) begin
                    e++;
                end
            end
            step();
        end
        bus.scan_ready = 1'b0;
        chk("scan_rows", 128'(e), 128'd64);
        chk("scan_busy_end", 128'(bus.scan_busy), 128'(1'b0));
        chk("scan_valid_end", 128'(bus.scan_valid), 128'(1'b0));
        chk("scan_end_ready", 128'(bus.req_ready), 128'(1'b1));

        // Reset in the middle of a scan, at row 30.
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        bus.scan_ready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            if (bus.scan_valid && (bus.scan_idx == 6'd30)) begin
                found = 1'b1;
            end else begin
                step();
            end
        end
        chk("reach_row30", 128'(found), 128'(1'b1));
        rst = 1'b1;
        #1;
        chk("abort_scan_valid", 128'(bus.scan_valid), 128'(1'b0));
        chk("abort_scan_busy", 128'(bus.scan_busy), 128'(1'b0));
        chk("abort_cen", 128'(bus.ram_CEN), 128'(1'b1));
        chk("abort_wen", 128'(bus.ram_WEN), 128'(1'b1));
        step();
        rst = 1'b0;
        #1;
        chk("abort_ready", 128'(bus.req_ready), 128'(1'b1));
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (bus.scan_valid) begin
                found = 1'b1;
            end else begin
                step();
            end
        end
        chk("restart_valid", 128'(found), 128'(1'b1));
        chk("restart_idx", 128'(bus.scan_idx), 128'd0);
        chk("restart_data", bus.scan_data, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_data_port_ctrl.md
# cache_data_port_ctrl

Initiator-side controller for the cache's 64×128-bit data RAM, which uses active-low CEN/WEN/BWEN and one-cycle registered read data. It turns 64-bit word requests from the cache FSM into RAM strobes, builds the per-bit write mask, and returns the selected read half through a valid/ready response. It also runs a row-scan mode that streams all 64 rows, for writeback/flush, through a second valid/ready port.

## Interface
- ROWS, 64, number of RAM rows; row address width is 6 bits.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  word request valid.
- req_ready  out  1  request accepted this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  7  bits [6:1] row, bit [0] half (0 = bits 63:0, 1 = bits 127:64).
- req_wdata  in  64  write data.
- req_wstrb  in  8  byte enables; bit b covers byte b of the word.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed.
- resp_rdata  out  64  read data; 0 for write responses.
- scan_start  in  1  pulse that starts a full-RAM scan.
- scan_busy  out  1  scan in progress.
- scan_valid  out  1  scan row valid.
- scan_ready  in  1  scan row consumed.
- scan_idx  out  6  row index of scan_data.
- scan_data  out  128  full row contents.
- ram_CEN  out  1  chip enable, active-low.
- ram_WEN  out  1  write enable, active-low.
- ram_A  out  6  row address.
- ram_BWEN  out  128  bit write enable, active-low (0 = write that bit).
- ram_D  out  128  write data.
- ram_Q  in  128  read data. Valid the cycle after a read strobe and held until the next read.

## Operation
- States: IDLE, RESP, SCAN_RD, SCAN_OUT.
- In IDLE, req_ready = 1 unless scan_start = 1 or reset = 1. Outside IDLE, req_ready = 0.
- RAM strobes are combinational from the accepting cycle, giving one-cycle latency.
- Read accept (IDLE):
  - ram_CEN = 0, ram_WEN = 1, ram_A = req_addr[6:1].
  - Register the half bit and go to RESP.
- Write accept (IDLE):
  - ram_CEN = 0, ram_WEN = 0, ram_A = row, ram_D = {req_wdata, req_wdata}.
  - ram_BWEN = all ones, except bits [h*64 + 8b +: 8] = ~{8{req_wstrb[b]}}, where h is the half bit.
  - Go to RESP.
  - If req_wstrb = 0, no RAM access (ram_CEN = 1), but RESP still follows.
- RESP:
  - resp_valid = 1.
  - resp_rdata = selected half of ram_Q for reads, 0 for writes.
  - On resp_ready, go to IDLE.
  - No RAM access occurs in RESP, so ram_Q stays stable under backpressure.
- Scan:
  - scan_start in IDLE has priority over a simultaneous req_valid; the request is not accepted.
  - scan_start outside IDLE is ignored.
  - On start: row counter = 0, enter SCAN_RD.
  - SCAN_RD: read row counter (ram_CEN = 0, ram_WEN = 1), then go to SCAN_OUT.
  - SCAN_OUT: scan_valid = 1, scan_data = ram_Q, scan_idx = counter.
  - On scan_ready: if counter = ROWS−1, go to IDLE; otherwise increment the counter and go to SCAN_RD.
  - scan_busy = 1 in SCAN_RD and SCAN_OUT.
- Idle RAM outputs: ram_CEN = 1, ram_WEN = 1, ram_BWEN = all ones, ram_A = 0, ram_D = 0.

## Timing
- Reset asserted: state = IDLE, row counter = 0, half register = 0.
- Outputs while reset is high:
  - req_ready = 0, resp_valid = 0, scan_valid = 0, scan_busy = 0.
  - resp_rdata = 0, scan_idx = 0.
  - ram_CEN = 1, ram_WEN = 1, ram_BWEN = all ones.
- req_ready rises the first cycle after reset deasserts.
- Read latency: accept at edge T, resp_valid from T+1, held until resp_ready.
- At most one request is outstanding. The next accept is no earlier than the cycle after the resp handshake, so throughput is 1 request per 2 cycles.
- Each scan row costs 2 cycles minimum: 128 cycles for a full scan with scan_ready tied high.
- The row counter saturates handling at ROWS−1. There is no wrap; the scan terminates.
- Reset mid-scan or mid-RESP aborts immediately: no further RAM strobes, and the pending response or row is dropped.

## Test plan
- Write to addr 0x05 (row 2, half 1), wdata 0x1122334455667788, wstrb 0xFF:
  - ram_WEN = 0, ram_A = 2, ram_BWEN[127:64] = 0, ram_BWEN[63:0] = all ones.
  - Reading 0x05 then returns 0x1122334455667788 on resp_rdata at T+1.
- Partial write to row 2 half 1 with wstrb 0x0F, wdata 0xAAAAAAAAAAAAAAAA:
  - Read of 0x05 returns 0x11223344AAAAAAAA.
  - Read of 0x04 (row 2, half 0) still returns the prior low-half value.
- Read with resp_ready held low for 5 cycles while a testbench model drives ram_Q from the RAM:
  - resp_valid and resp_rdata stay stable throughout.
  - req_ready = 0 and ram_CEN = 1 during the stall.
- Write with wstrb 0:
  - ram_CEN stays 1 and RAM contents are unchanged.
  - One write response is produced with resp_rdata = 0.
- Scan after writing row r with {64'r, 64'r}, with scan_ready toggling randomly:
  - 64 rows appear in order, scan_idx 0..63, with matching data.
  - scan_busy drops after row 63.
  - A req_valid asserted in the scan_start cycle is not accepted.
- Assert reset at row 30 of a scan:
  - scan_valid, scan_busy and RAM strobes are inactive immediately.
  - After release, req_ready = 1 and a new scan restarts at scan_idx = 0.
